// File: rtl/adder_share_arb.sv
// adder_share_arb: arbitrates two requesters onto one external adder.
// A granted request has its operands registered onto the adder inputs.
// The sum and the overflow flag are captured one cycle later.
// They are then held for the owning port until it takes them.
module adder_share_arb #(
  parameter int WIDTH = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [WIDTH-1:0] i_req_a0,
  input  logic [WIDTH-1:0] i_req_b0,
  input  logic [WIDTH-1:0] i_req_a1,
  input  logic [WIDTH-1:0] i_req_b1,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_sum,
  output logic             o_rsp_err,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  input  logic [WIDTH-1:0] i_add_sum,
  input  logic             i_add_err,
  output logic             o_busy,
  output logic [15:0]      o_op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_grant;
  logic             w_grant_vld;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             r_owner;
  logic             r_last_grant;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_busy;
  logic [15:0]      r_op_count;

  // Grant selection: a lone requester wins.
  // On contention, the port not granted last time wins, or port 0 when RR is off.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_vld = 1'b0;
    case (i_req_valid)
      2'b01: begin
        w_grant     = 1'b0;
        w_grant_vld = 1'b1;
      end
      2'b10: begin
        w_grant     = 1'b1;
        w_grant_vld = 1'b1;
      end
      2'b11: begin
        w_grant_vld = 1'b1;
        if (RR_EN != 1'b0) begin
          w_grant = ~r_last_grant;
        end else begin
          w_grant = 1'b0;
        end
      end
      default: begin
        w_grant     = 1'b0;
        w_grant_vld = 1'b0;
      end
    endcase
  end

  // Next-state logic plus request-ready and handshake strobes
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 2'b00;
    w_accept     = 1'b0;
    w_rsp_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          o_req_ready  = w_grant ? 2'b10 : 2'b01;
          w_accept     = 1'b1;
          w_state_next = ST_ADD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ADD: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready bit can release the response
        if (i_rsp_ready[r_owner]) begin
          w_rsp_hs     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath, grant history, response and completion counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_add_a      <= {WIDTH{1'b0}};
      r_add_b      <= {WIDTH{1'b0}};
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 2'b00;
      r_rsp_sum    <= {WIDTH{1'b0}};
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_op_count   <= 16'h0000;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      // Adder operands change only on accept, so the adder input is quiet otherwise
      if (w_accept) begin
        r_add_a      <= w_grant ? i_req_a1 : i_req_a0;
        r_add_b      <= w_grant ? i_req_b1 : i_req_b0;
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == ST_ADD) begin
        r_rsp_sum   <= i_add_sum;
        r_rsp_err   <= i_add_err;
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 2'b00;
        r_op_count  <= r_op_count + 16'h0001;
      end
    end
  end

  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb.
// Two instances share the stimulus: one round-robin, one fixed priority.
module tb_adder_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_sum, add_a, add_b, add_sum, op_count;
  logic        rsp_err, add_err, busy;

  logic [1:0]  fp_req_ready, fp_rsp_valid;
  logic [15:0] fp_rsp_sum, fp_add_a, fp_add_b, fp_add_sum, fp_op_count;
  logic        fp_rsp_err, fp_add_err, fp_busy;

  int errors = 0;
  int checks = 0;
  int rr_last;

  always #5 clk = ~clk;

  // Signed overflow: the true signed sum does not fit in 16 bits
  function automatic logic ovf(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // External adders modelled behaviourally
  assign add_sum    = add_a + add_b;
  assign add_err    = ovf(add_a, add_b);
  assign fp_add_sum = fp_add_a + fp_add_b;
  assign fp_add_err = ovf(fp_add_a, fp_add_b);

  adder_share_arb #(.WIDTH(16), .RR_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_sum(rsp_sum),
    .o_rsp_err(rsp_err), .o_add_a(add_a), .o_add_b(add_b), .i_add_sum(add_sum),
    .i_add_err(add_err), .o_busy(busy), .o_op_count(op_count)
  );

  adder_share_arb #(.WIDTH(16), .RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(fp_req_ready),
    .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
    .o_rsp_valid(fp_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_sum(fp_rsp_sum),
    .o_rsp_err(fp_rsp_err), .o_add_a(fp_add_a), .o_add_b(fp_add_b), .i_add_sum(fp_add_sum),
    .i_add_err(fp_add_err), .o_busy(fp_busy), .o_op_count(fp_op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();
    step();
    rst = 1'b0;
    rr_last = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_sum !== 16'h0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0000/0", rsp_sum, rsp_err); end
    checks++; if (add_a !== 16'h0000 || add_b !== 16'h0000) begin errors++; $display("FAIL reset_add got=%h/%h exp=0000/0000", add_a, add_b); end
    checks++; if (busy !== 1'b0 || fp_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy, fp_busy); end
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
  endtask

  task automatic test_single();
    do_reset();
    a0 = 16'h7FFF; b0 = 16'h0001; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_add_phase got=%b/%b exp=00/1", rsp_valid, busy); end
    checks++; if (add_a !== 16'h7FFF || add_b !== 16'h0001) begin errors++; $display("FAIL single_operands got=%h/%h exp=7fff/0001", add_a, add_b); end
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_sum !== 16'h8000 || rsp_err !== 1'b1) begin errors++; $display("FAIL single_result got=%h/%b exp=8000/1", rsp_sum, rsp_err); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++; if (op_count !== 16'h0001 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_done got=%h/%b exp=0001/00", op_count, rsp_valid); end
  endtask

  task automatic test_contention_first();
    do_reset();
    a0 = 16'h0003; b0 = 16'h0004; a1 = 16'h8000; b1 = 16'h8000;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL first_grant got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b10;
    step();
    checks++; if (rsp_valid !== 2'b01 || rsp_sum !== 16'h0007 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL first_rsp0 got=%b/%h/%b exp=01/0007/0", rsp_valid, rsp_sum, rsp_err); end
    step();
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL second_grant got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 2'b10 || rsp_sum !== 16'h0000 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL first_rsp1 got=%b/%h/%b exp=10/0000/1", rsp_valid, rsp_sum, rsp_err); end
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_alternate();
    logic [15:0] s0, s1;
    logic        e0, e1, exp_port;
    int          n_rr, n_fp;
    do_reset();
    a0 = pick_op(); b0 = pick_op(); a1 = pick_op(); b1 = pick_op();
    s0 = a0 + b0; s1 = a1 + b1; e0 = ovf(a0, b0); e1 = ovf(a1, b1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    exp_port = 1'b0; n_rr = 0; n_fp = 0;
    #1;
    checks++; if (req_ready !== 2'b01 || fp_req_ready !== 2'b01) begin
      errors++; $display("FAIL alt_first_ready got=%b/%b exp=01/01", req_ready, fp_req_ready); end
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid !== 2'b00) begin
        checks++;
        if (rsp_valid !== (exp_port ? 2'b10 : 2'b01) || rsp_sum !== (exp_port ? s1 : s0) || rsp_err !== (exp_port ? e1 : e0)) begin
          errors++; $display("FAIL rr_alternate got=%b/%h/%b exp=%b/%h/%b", rsp_valid, rsp_sum, rsp_err,
                             exp_port ? 2'b10 : 2'b01, exp_port ? s1 : s0, exp_port ? e1 : e0);
        end
        exp_port = ~exp_port;
        n_rr++;
      end
      if (fp_rsp_valid !== 2'b00) begin
        checks++;
        if (fp_rsp_valid !== 2'b01 || fp_rsp_sum !== s0 || fp_rsp_err !== e0) begin
          errors++; $display("FAIL fp_priority got=%b/%h/%b exp=01/%h/%b", fp_rsp_valid, fp_rsp_sum, fp_rsp_err, s0, e0);
        end
        n_fp++;
      end
    end
    req_valid = 2'b00;
    checks++; if (n_rr != 10 || n_fp != 10) begin errors++; $display("FAIL alt_rsp_count got=%0d/%0d exp=10/10", n_rr, n_fp); end
    checks++; if (op_count !== 16'd10 || fp_op_count !== 16'd10) begin errors++; $display("FAIL alt_op_count got=%0d/%0d exp=10/10", op_count, fp_op_count); end
    step();
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_hold();
    logic [15:0] a, b, s;
    logic        e;
    do_reset();
    a = pick_op(); b = pick_op(); s = a + b; e = ovf(a, b);
    a0 = a; b0 = b; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    for (int k = 0; k < 8; k++) begin
      rsp_ready = (k < 5) ? 2'b00 : 2'b10;
      req_valid = 2'b11;
      a0 = 16'($urandom); a1 = 16'($urandom);
      step();
      checks++;
      if (rsp_valid !== 2'b01 || rsp_sum !== s || rsp_err !== e || req_ready !== 2'b00 || add_a !== a || add_b !== b) begin
        errors++; $display("FAIL hold_stable k=%0d got=%b/%h/%b/%b/%h exp=01/%h/%b/00/%h", k, rsp_valid, rsp_sum, rsp_err, req_ready, add_a, s, e, a);
      end
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || op_count !== 16'h0001) begin errors++; $display("FAIL hold_release got=%b/%h exp=00/0001", rsp_valid, op_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a0 = 16'h1234; b0 = 16'h1111; req_valid = 2'b01; rsp_ready = 2'b01;
    step(); req_valid = 2'b00; step(); step();
    checks++; if (op_count !== 16'h0001) begin errors++; $display("FAIL abort_pre_count got=%h exp=0001", op_count); end
    a0 = 16'h4321; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || op_count !== 16'h0000) begin
      errors++; $display("FAIL abort_state got=%b/%b/%h exp=0/00/0000", busy, rsp_valid, op_count); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL abort_no_rsp k=%0d got=%b exp=00", k, rsp_valid); end
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [15:0] a, b, s, cnt;
    logic        e, g;
    logic [1:0]  pat;
    int          d;
    do_reset();
    cnt = 16'h0000;
    for (int n = 0; n < 200; n++) begin
      if (n == 0) begin
        pat = 2'b10; a1 = 16'hFFFF; b1 = 16'h0001;
      end else begin
        pat = 2'($urandom_range(1, 3));
        a0 = pick_op(); b0 = pick_op(); a1 = pick_op(); b1 = pick_op();
      end
      if (pat == 2'b11) g = (rr_last == 0);
      else              g = (pat == 2'b10);
      rr_last = g ? 1 : 0;
      a = g ? a1 : a0; b = g ? b1 : b0;
      s = a + b; e = ovf(a, b);
      req_valid = pat;
      #1;
      checks++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, req_ready, g ? 2'b10 : 2'b01); end
      step();
      req_valid = 2'b00;
      step();
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        rsp_ready = g ? 2'b01 : 2'b10;
        step();
      end
      checks++;
      if (rsp_valid !== (g ? 2'b10 : 2'b01) || rsp_sum !== s || rsp_err !== e) begin
        errors++; $display("FAIL rand_rsp n=%0d got=%b/%h/%b exp=%b/%h/%b", n, rsp_valid, rsp_sum, rsp_err, g ? 2'b10 : 2'b01, s, e);
      end
      rsp_ready = g ? 2'b10 : 2'b01;
      step();
      rsp_ready = 2'b00;
      cnt = cnt + 16'h0001;
    end
    checks++; if (op_count !== cnt) begin errors++; $display("FAIL rand_op_count got=%h exp=%h", op_count, cnt); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    a0 = 16'h0000; b0 = 16'h0000; a1 = 16'h0000; b1 = 16'h0000;
    rr_last = 1;
    test_reset();
    test_single();
    test_contention_first();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
